// File: rtl/generic_bus_arbiter_pkg.sv
// Shared types and helpers for the generic bus arbiter.
// Optional GEN_BUS_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
package gen_bus_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/generic_bus_arbiter_rr_picker.sv
// Combinational winner selection for the bus arbiter.
// GEN_BUS_ARB_FIXED_PRIO_EN turns it into a lowest-index priority encoder.
module rr_picker
  import gen_bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output logic               any_req
);

`ifdef GEN_BUS_ARB_FIXED_PRIO_EN

  // Lowest requesting index wins; scan downward so it is written last.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IW'(i);
    end
  end

`else

  int  idx;
  logic found;

  // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first hit wins.
  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/generic_bus_arbiter.sv
// N-master generic-bus arbiter onto one slave port, registered outputs.
// Optional GEN_BUS_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority.
module generic_bus_arbiter
  import gen_bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  req_byte_en,
  input  logic [NUM_REQ-1:0]           req_ren,
  input  logic [NUM_REQ-1:0]           req_wen,
  output logic [DATA_W-1:0]            req_rdata,
  output logic [NUM_REQ-1:0]           req_busy,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [DATA_W-1:0]            out_wdata,
  output logic [DATA_W/8-1:0]          out_byte_en,
  output logic                         out_ren,
  output logic                         out_wen,
  input  logic [DATA_W-1:0]            out_rdata,
  input  logic                         out_busy,
  output logic [idx_w(NUM_REQ)-1:0]    grant_idx,
  output logic                         grant_valid
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = DATA_W / 8;

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [NUM_REQ-1:0] req;
  logic [IW-1:0]      winner;
  logic [IW-1:0]      rr_ptr;
  logic               any_req;
  logic               load;
  logic               done;
  logic               win_wen;
  logic               win_ren;

  assign req = req_ren | req_wen;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // A master asserting both strobes is treated as a write.
  assign win_wen = req_wen[winner];
  assign win_ren = req_ren[winner] & ~win_wen;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the load/done strobes for the datapath.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          load    = 1'b1;
        end
      end
      ACCESS: begin
        if (!out_busy) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GEN_BUS_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // Rotate priority to the master after the one just served.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= '0;
    end else if (done) begin
      if (grant_idx == IW'(NUM_REQ - 1)) rr_ptr <= '0;
      else                               rr_ptr <= grant_idx + 1'b1;
    end
  end
`endif

  // Latch the winner's request; hold it until the slave finishes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_addr    <= '0;
      out_wdata   <= '0;
      out_byte_en <= '0;
      out_ren     <= 1'b0;
      out_wen     <= 1'b0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else if (load) begin
      out_addr    <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
      out_wdata   <= req_wdata[int'(winner)*DATA_W +: DATA_W];
      out_byte_en <= req_byte_en[int'(winner)*BW +: BW];
      out_ren     <= win_ren;
      out_wen     <= win_wen;
      grant_idx   <= winner;
      grant_valid <= 1'b1;
    end else if (done) begin
      out_ren     <= 1'b0;
      out_wen     <= 1'b0;
      grant_valid <= 1'b0;
    end
  end

  // Only the owner sees busy drop, and only in its completion cycle.
  always_comb begin
    req_busy = '1;
    if (state_q == ACCESS && !out_busy && !RST) begin
      req_busy[grant_idx] = 1'b0;
    end
  end

  assign req_rdata = out_rdata;

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Scoreboard bench for generic_bus_arbiter with four masters.
// Honours GEN_BUS_ARB_FIXED_PRIO_EN for the contention grant order.
module tb_generic_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_byte_en = '0;
  logic [N-1:0]    req_ren = '0;
  logic [N-1:0]    req_wen = '0;
  logic [DW-1:0]   req_rdata;
  logic [N-1:0]    req_busy;
  logic [AW-1:0]   out_addr;
  logic [DW-1:0]   out_wdata;
  logic [3:0]      out_byte_en;
  logic            out_ren;
  logic            out_wen;
  logic [DW-1:0]   slave_data = '0;
  logic            out_busy = 1'b1;
  logic [1:0]      grant_idx;
  logic            grant_valid;

  generic_bus_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_byte_en (req_byte_en),
    .req_ren     (req_ren),
    .req_wen     (req_wen),
    .req_rdata   (req_rdata),
    .req_busy    (req_busy),
    .out_addr    (out_addr),
    .out_wdata   (out_wdata),
    .out_byte_en (out_byte_en),
    .out_ren     (out_ren),
    .out_wen     (out_wen),
    .out_rdata   (slave_data),
    .out_busy    (out_busy),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        ren;
    logic        wen;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   slave_wait = 0;
  int   wcnt = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] rd);
    exp_t e;
    e.idx = i; e.addr = a; e.wdata = d; e.be = b;
    e.ren = r; e.wen = w; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic req_on(input int i, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_byte_en[i*4 +: 4] = b;
    req_ren[i] = r;
    req_wen[i] = w;
  endtask

  task automatic req_off(input int i);
    req_ren[i] = 1'b0;
    req_wen[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge CLK); #1;
      if (!req_busy[i]) break;
    end
    if (n == 60) begin
      total++;
      bad++;
      $display("FAIL timeout master=%0d act=busy exp=done", i);
    end
  endtask

  task automatic master_seq(input int i, input int reps);
    for (int r = 0; r < reps; r++) begin
      req_on(i, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'hF);
      wait_done(i);
      req_off(i);
      @(negedge CLK);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  // Slave model: busy for slave_wait cycles, then done for one cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (out_ren | out_wen) begin
        out_busy = (wcnt < slave_wait);
        wcnt++;
      end else begin
        wcnt = 0;
        out_busy = 1'b1;
      end
    end
  end

  // Monitor: check held outputs against the head, pop on completion.
  initial begin
    int lows;
    int li;
    exp_t e;
    forever begin
      @(negedge CLK); #2;
      if (!RST) begin
        lows = 0;
        li = 0;
        for (int i = 0; i < N; i++) begin
          if (!req_busy[i]) begin
            lows++;
            li = i;
          end
        end
        if (grant_valid) begin
          if (exp_q.size() == 0) begin
            chk("grant_unexpected", 64'(grant_valid), 64'd0);
          end else begin
            e = exp_q[0];
            chk("grant_idx", 64'(grant_idx), 64'(e.idx));
            chk("out_addr", 64'(out_addr), 64'(e.addr));
            chk("out_wdata", 64'(out_wdata), 64'(e.wdata));
            chk("out_byte_en", 64'(out_byte_en), 64'(e.be));
            chk("out_ren", 64'(out_ren), 64'(e.ren));
            chk("out_wen", 64'(out_wen), 64'(e.wen));
          end
        end
        if (lows > 0) begin
          chk("one_busy_low", 64'(lows), 64'd1);
          if (exp_q.size() == 0) begin
            chk("done_unexpected", 64'(lows), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_idx", 64'(li), 64'(e.idx));
            if (e.ren) chk("req_rdata", 64'(req_rdata), 64'(e.rdata));
            done_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    int ord[5];

    // Reset held with masters 0 and 1 reading.
    slave_wait = 1;
    slave_data = 32'h1111_0000;
    req_on(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    req_on(1, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
    push_exp(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1111_0000);
    push_exp(1, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 32'h1111_0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); #3;
      chk("rst_out_ren", 64'(out_ren), 64'd0);
      chk("rst_req_busy", 64'(req_busy), 64'hF);
      chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    end
    #1 RST = 1'b0;
    wait_done(0);
    req_off(0);
    wait_done(1);
    req_off(1);
    @(negedge CLK);

    // Single read by master 1 with two wait cycles.
    slave_wait = 2;
    slave_data = 32'hDEAD_BEEF;
    push_exp(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF);
    req_on(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    @(negedge CLK); #3;
    chk("read_addr_next_cycle", 64'(out_addr), 64'h100);
    wait_done(1);
    req_off(1);
    @(negedge CLK);

    // Contention from a fresh pointer, zero-wait slave.
    apply_reset();
    slave_wait = 0;
    slave_data = 32'h0C0C_0C0C;
`ifdef GEN_BUS_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 1, 2, 3};
`else
    ord = '{0, 1, 2, 3, 0};
`endif
    for (int k = 0; k < 5; k++) begin
      push_exp(ord[k], 1'b1, 1'b0, 32'h1000 + 32'(ord[k] * 4),
               32'h0, 4'hF, 32'h0C0C_0C0C);
    end
    done_cyc.delete();
    fork
      master_seq(0, 2);
      master_seq(1, 1);
      master_seq(2, 1);
      master_seq(3, 1);
    join
    chk("contention_count", 64'(done_cyc.size()), 64'd5);
    for (int k = 1; k < done_cyc.size(); k++) begin
      chk("contention_gap", 64'(done_cyc[k] - done_cyc[k-1]), 64'd2);
    end

    // Master 2 write with byte enables, three busy cycles.
    slave_wait = 3;
    push_exp(2, 1'b0, 1'b1, 32'h2004, 32'h1234_5678, 4'b0011, 32'h0);
    req_on(2, 1'b0, 1'b1, 32'h2004, 32'h1234_5678, 4'b0011);
    @(negedge CLK); #1;
    req_wdata[2*DW +: DW] = 32'hFFFF_FFFF;
    req_addr[2*AW +: AW]  = 32'h9999;
    wait_done(2);
    req_off(2);
    @(negedge CLK);

    // Both strobes on master 0 become a write.
    slave_wait = 0;
    push_exp(0, 1'b0, 1'b1, 32'h40, 32'hA5A5_5A5A, 4'hF, 32'h0);
    req_on(0, 1'b1, 1'b1, 32'h40, 32'hA5A5_5A5A, 4'hF);
    wait_done(0);
    req_off(0);
    @(negedge CLK);

    // Reset during ACCESS abandons the transaction.
    slave_wait = 10;
    push_exp(3, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0);
    req_on(3, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    repeat (2) @(negedge CLK);
    #3 RST = 1'b1;
    req_off(3);
    @(negedge CLK); #3;
    chk("rst_access_out_ren", 64'(out_ren), 64'd0);
    chk("rst_access_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_access_busy", 64'(req_busy), 64'hF);
    RST = 1'b0;
    chk("rst_access_no_done", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (3) @(negedge CLK);

    // Recovery read by master 2.
    slave_wait = 1;
    slave_data = 32'hCAFE_F00D;
    push_exp(2, 1'b1, 1'b0, 32'h2200, 32'h0, 4'hF, 32'hCAFE_F00D);
    req_on(2, 1'b1, 1'b0, 32'h2200, 32'h0, 4'hF);
    wait_done(2);
    req_off(2);
    repeat (3) @(negedge CLK);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
